fmap_pingpong_ram: RTL and testbench

Parametrised double-buffered (ping-pong) feature-map RAM for LeNet layer outputs, the successor of the fixed 96-bit x 256 single-buffer layer RAMs. A producer layer fills one bank while the consumer layer reads the other. Bank ownership is handed over with explicit last/release handshakes. Adds configurable read latency, read-valid tracking and drop-error flags.

---
 rtl/lenet_mem_pkg.sv | 22 ++
 rtl/sdp_ram_infer.sv | 32 +++
 rtl/fmap_pingpong_ram.sv | 134 +++++++++++++
 tb/tb_fmap_pingpong_ram.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lenet_mem_pkg.sv
// rtl/lenet_mem_pkg.sv - shared LeNet feature-map memory constants and types
package lenet_mem_pkg;

  localparam int C1_DATA_W = 96;
  localparam int C1_DEPTH  = 196;
  localparam int C3_DATA_W = 96;
  localparam int C3_DEPTH  = 200;
  localparam int F3_DATA_W = 96;
  localparam int F3_DEPTH  = 120;
  localparam int F4_DATA_W = 96;
  localparam int F4_DEPTH  = 84;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef logic bank_t;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sdp_ram_infer.sv
// rtl/sdp_ram_infer.sv - inferred simple dual-port RAM with registered read port
module sdp_ram_infer #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register only moves on a real read so dropped reads leave rdata intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fmap_pingpong_ram.sv
// rtl/fmap_pingpong_ram.sv - double-buffered feature-map RAM with bank handover
module fmap_pingpong_ram
  import lenet_mem_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              wr_bank,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_avail,
  output logic              rd_bank,
  input  logic              rd_release,
  output logic              err_wr_drop,
  output logic              err_rd_drop
);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("fmap_pingpong_ram: RD_LAT must be 1 or 2");
  end

  localparam int RAM_AW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        full_q, full_d;
  bank_t             wsel_q, wsel_d, rsel_q, rsel_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              err_wr_q, err_wr_d, err_rd_q, err_rd_d;

  logic              wr_in_range, rd_in_range;
  logic              wr_acc, rd_acc, rel_acc;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_ready    = !full_q[wsel_q];
  assign rd_avail    = full_q[rsel_q];
  assign wr_bank     = wsel_q;
  assign rd_bank     = rsel_q;
  assign err_wr_drop = err_wr_q;
  assign err_rd_drop = err_rd_q;
  assign rd_valid    = vld_q[RD_LAT-1];

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
  assign wr_acc      = wr_en && wr_ready && wr_in_range;
  assign rd_acc      = rd_en && rd_avail && rd_in_range;
  assign rel_acc     = rd_release && rd_avail;

  // Bank 1 sits at offset DEPTH; for power-of-two DEPTH this is just the address MSB.
  assign ram_waddr = wsel_q ? ({1'b0, wr_addr} + DEPTH_C) : {1'b0, wr_addr};
  assign ram_raddr = rsel_q ? ({1'b0, rd_addr} + DEPTH_C) : {1'b0, rd_addr};

  always_comb begin
    full_d   = full_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    err_wr_d = err_wr_q;
    err_rd_d = err_rd_q;
    vld_d    = '0;
    // A completing write and a release can never name the same bank.
    if (wr_acc && wr_last) begin
      full_d[wsel_q] = 1'b1;
      wsel_d         = !wsel_q;
    end
    if (rel_acc) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = !rsel_q;
    end
    if (wr_en && !wr_acc) err_wr_d = 1'b1;
    if (rd_en && !rd_acc) err_rd_d = 1'b1;
    vld_d[0] = rd_acc;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      vld_q    <= '0;
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      vld_q    <= vld_d;
      err_wr_q <= err_wr_d;
      err_rd_q <= err_rd_d;
    end
  end

  sdp_ram_infer #(
    .DATA_W (DATA_W),
    .DEPTH  (2 * DEPTH),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (ram_waddr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] out_q, out_d;
    always_comb begin
      out_d = out_q;
      if (vld_q[0]) out_d = ram_rdata;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
    end
    assign rd_data = out_q;
  end else begin : g_lat1
    assign rd_data = ram_rdata;
  end

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// tb/tb_fmap_pingpong_ram.sv - checks both read latencies against a bank-level model
module tb_fmap_pingpong_ram;

  localparam int DW = 96;
  localparam int DP = 120;
  localparam int AW = 7;

  logic          clk;
  logic          rst;
  logic          wr_en, wr_last, rd_en, rd_release;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic          wr_ready1, wr_bank1, rd_valid1, rd_avail1, rd_bank1, err_w1, err_r1;
  logic          wr_ready2, wr_bank2, rd_valid2, rd_avail2, rd_bank2, err_w2, err_r2;
  logic [DW-1:0] rd_data1, rd_data2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  fmap_pingpong_ram #(.DATA_W(DW), .DEPTH(DP), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready1), .wr_bank(wr_bank1), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_avail(rd_avail1),
    .rd_bank(rd_bank1), .rd_release(rd_release), .err_wr_drop(err_w1), .err_rd_drop(err_r1)
  );

  fmap_pingpong_ram #(.DATA_W(DW), .DEPTH(DP), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready2), .wr_bank(wr_bank2), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_avail(rd_avail2),
    .rd_bank(rd_bank2), .rd_release(rd_release), .err_wr_drop(err_w2), .err_rd_drop(err_r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bank-level model: two arrays, a full flag per bank, writer/reader pointers,
  // and a list of reads due at a given edge for each latency.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] m_mem [2][DP];
  bit            m_full [2];
  bit            m_wsel, m_rsel, m_ew, m_er;
  int            cyc = 0;
  rd_t           q1[$], q2[$];
  bit            e_v1, e_v2;
  logic [DW-1:0] e_d1 = '0, e_d2 = '0;

  always @(posedge clk or posedge rst) begin : model
    bit            wacc, racc, rel;
    logic [DW-1:0] rv;
    rd_t           item;
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0;
      m_wsel = 0; m_rsel = 0; m_ew = 0; m_er = 0;
      q1.delete(); q2.delete();
      e_v1 = 0; e_v2 = 0; e_d1 = '0; e_d2 = '0;
    end else begin
      cyc++;
      wacc = wr_en && !m_full[m_wsel] && (int'(wr_addr) < DP);
      racc = rd_en && m_full[m_rsel] && (int'(rd_addr) < DP);
      rel  = rd_release && m_full[m_rsel];
      if (wr_en && !wacc) m_ew = 1;
      if (rd_en && !racc) m_er = 1;
      if (racc) begin
        rv = m_mem[m_rsel][rd_addr];
        item.d = rv;
        item.due = cyc;     q1.push_back(item);
        item.due = cyc + 1; q2.push_back(item);
      end
      if (wacc) begin
        m_mem[m_wsel][wr_addr] = wr_data;
        if (wr_last) begin
          m_full[m_wsel] = 1;
          m_wsel = !m_wsel;
        end
      end
      if (rel) begin
        m_full[m_rsel] = 0;
        m_rsel = !m_rsel;
      end
      e_v1 = 0; e_v2 = 0;
      if (q1.size() > 0 && q1[0].due == cyc) begin e_v1 = 1; e_d1 = q1[0].d; q1.pop_front(); end
      if (q2.size() > 0 && q2[0].due == cyc) begin e_v2 = 1; e_d2 = q2[0].d; q2.pop_front(); end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("wr_ready1", wr_ready1, !m_full[m_wsel]);
      chk("rd_avail1", rd_avail1, m_full[m_rsel]);
      chk("wr_bank1",  wr_bank1,  m_wsel);
      chk("rd_bank1",  rd_bank1,  m_rsel);
      chk("err_w1",    err_w1,    m_ew);
      chk("err_r1",    err_r1,    m_er);
      chk("rd_valid1", rd_valid1, e_v1);
      chk("rd_data1",  rd_data1,  e_d1);
      chk("wr_ready2", wr_ready2, !m_full[m_wsel]);
      chk("rd_avail2", rd_avail2, m_full[m_rsel]);
      chk("wr_bank2",  wr_bank2,  m_wsel);
      chk("rd_bank2",  rd_bank2,  m_rsel);
      chk("err_w2",    err_w2,    m_ew);
      chk("err_r2",    err_r2,    m_er);
      chk("rd_valid2", rd_valid2, e_v2);
      chk("rd_data2",  rd_data2,  e_d2);
    end
  end

  task automatic step(input bit we, input int wa, input logic [DW-1:0] wd, input bit wl,
                      input bit re, input int ra, input bit rl);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_last = wl;
    rd_en = re; rd_addr = AW'(ra); rd_release = rl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
    rd_en = 0; rd_addr = '0; rd_release = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1;
    chk("rst_wr_ready", wr_ready1, 1);
    chk("rst_rd_avail", rd_avail1, 0);
    chk("rst_wr_bank",  wr_bank1, 0);
    chk("rst_rd_data2", rd_data2, 0);

    for (int a = 0; a < DP; a++) step(1, a, DW'(a), a == DP - 1, 0, 0, 0);
    chk("fill0_wr_bank",  wr_bank1, 1);
    chk("fill0_rd_avail", rd_avail1, 1);
    chk("fill0_rd_bank",  rd_bank1, 0);
    chk("fill0_wr_ready", wr_ready1, 1);

    step(0, 0, '0, 0, 1, 5, 0);
    chk("lat1_v_a", rd_valid1, 1); chk("lat1_d_a", rd_data1, 5); chk("lat2_v_a", rd_valid2, 0);
    step(0, 0, '0, 0, 1, 6, 0);
    chk("lat1_d_b", rd_data1, 6); chk("lat2_v_b", rd_valid2, 1); chk("lat2_d_b", rd_data2, 5);
    idle();
    chk("lat1_v_c", rd_valid1, 0); chk("lat2_v_c", rd_valid2, 1); chk("lat2_d_c", rd_data2, 6);
    idle();
    chk("lat2_v_d", rd_valid2, 0);

    for (int a = 0; a < DP; a++) step(1, a, DW'('h100 + a), a == DP - 1, 0, 0, 0);
    chk("both_full_wr_ready", wr_ready1, 0);
    step(1, 3, DW'('hAA), 0, 0, 0, 0);
    chk("wr_drop_err1", err_w1, 1); chk("wr_drop_err2", err_w2, 1);
    step(0, 0, '0, 0, 0, 0, 1);
    chk("rel_rd_bank", rd_bank1, 1); chk("rel_wr_ready", wr_ready1, 1);
    step(0, 0, '0, 0, 1, 3, 0);
    chk("bank1_addr3", rd_data1, 'h103);
    idle(); idle();
    step(0, 0, '0, 0, 1, 127, 0);
    chk("rd_oor_valid", rd_valid1, 0); chk("rd_oor_hold", rd_data1, 'h103); chk("rd_oor_err", err_r1, 1);
    idle();
    chk("rd_oor_hold2", rd_data2, 'h103);

    for (int a = 0; a < DP - 1; a++) step(1, a, DW'('h200 + a), 0, 0, 0, 0);
    step(1, DP - 1, DW'('h200 + DP - 1), 1, 1, 7, 1);
    chk("sim_old_bank_rd", rd_data1, 'h107);
    chk("sim_rd_bank", rd_bank1, 0); chk("sim_wr_bank", wr_bank1, 1);
    chk("sim_wr_ready", wr_ready1, 1); chk("sim_rd_avail", rd_avail1, 1);
    for (int a = 0; a < DP; a++) step(0, 0, '0, 0, 1, a, 0);
    chk("map_last1", rd_data1, 'h200 + DP - 1);
    idle(); idle();

    step(0, 0, '0, 0, 0, 0, 1);
    chk("empty_rd_avail", rd_avail1, 0); chk("empty_wr_ready", wr_ready1, 1);
    step(0, 0, '0, 0, 0, 0, 1);
    chk("ign_rel_rd_bank", rd_bank1, 1);
    step(0, 0, '0, 0, 1, 0, 0);
    chk("rd_empty_valid", rd_valid1, 0);
    step(1, 127, DW'('hBAD), 1, 0, 0, 0);
    chk("wr_oor_bank", wr_bank1, 1);

    for (int a = 0; a < DP; a++) step(1, a, DW'('h300 + a), a == DP - 1, 0, 0, 0);
    chk("fill1_avail", rd_avail1, 1);
    step(0, 0, '0, 0, 1, 4, 0);
    chk("pre_rst_valid1", rd_valid1, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid1", rd_valid1, 0); chk("arst_valid2", rd_valid2, 0);
    chk("arst_data1", rd_data1, 0);   chk("arst_data2", rd_data2, 0);
    chk("arst_wr_ready", wr_ready1, 1); chk("arst_rd_avail", rd_avail1, 0);
    chk("arst_wr_bank", wr_bank2, 0);   chk("arst_rd_bank", rd_bank2, 0);
    chk("arst_err_w", err_w1, 0);       chk("arst_err_r", err_r2, 0);
    @(posedge clk); #1;
    chk("arst_valid2_late", rd_valid2, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(); idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
